// File: rtl/mr2mmm_pkg.sv
// Shared types and constants for the radix-2 Montgomery multiplier.
// Holds the controller state encoding and the default operand width.
// No logic; imported by the step datapath and the top.
package mr2mmm_pkg;

  localparam int M_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    CORR = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mr2mmm_step.sv
// One radix-2 Montgomery iteration: S' = (S + a_i*B + q*N) / 2.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle, consumed only while iterating.
module mr2mmm_step
  import mr2mmm_pkg::*;
#(
  parameter int M = M_DEFAULT
) (
  input  logic [M+1:0] s_i,
  input  logic         a_bit_i,
  input  logic [M-1:0] b_i,
  input  logic [M-1:0] n_i,
  output logic [M+1:0] s_o
);

  logic         q;
  logic [M+2:0] add_b;
  logic [M+2:0] add_n;
  logic [M+2:0] sum;

  // q makes the sum even so the shift divides exactly by two.
  always_comb begin
    q     = s_i[0] ^ (a_bit_i & b_i[0]);
    add_b = a_bit_i ? {3'b000, b_i} : '0;
    add_n = q ? {3'b000, n_i} : '0;
    sum   = {1'b0, s_i} + add_b + add_n;
    s_o   = (M + 2)'(sum >> 1);
  end

endmodule

// File: rtl/mr2mmm_unit.sv
// Sequential Montgomery multiplier: result = A*B*2^-M mod N (N odd).
// Latency: M+1 cycles from accept to done for odd N, done next cycle for even N.
// Backpressure: start is only sampled in IDLE; busy marks the unit occupied.
module mr2mmm_unit
  import mr2mmm_pkg::*;
#(
  parameter int M = M_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sq,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  input  logic [M-1:0] n,
  output logic [M-1:0] result,
  output logic         done,
  output logic         busy,
  output logic         err
);

  localparam int             CW   = $clog2(M + 1);
  localparam logic [CW-1:0]  LAST = CW'(M - 1);

  state_e        state_q, state_d;
  logic [M-1:0]  a_q, b_q, n_q, result_q;
  logic          err_q;
  logic [M+1:0]  s_q, s_next;
  logic [CW-1:0] cnt_q;
  logic          s_ge_n;

  // Multiplier bits are consumed LSB first by shifting the A register.
  mr2mmm_step #(.M(M)) u_step (
    .s_i     (s_q),
    .a_bit_i (a_q[0]),
    .b_i     (b_q),
    .n_i     (n_q),
    .s_o     (s_next)
  );

  assign s_ge_n = (s_q >= {2'b00, n_q});

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: even modulus skips straight to DONE with an error flag.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = n[0] ? ITER : DONE;
      ITER: if (cnt_q == LAST) state_d = CORR;
      CORR: state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from the state alone.
  always_comb begin
    done = (state_q == DONE);
    busy = (state_q != IDLE);
  end

  // Operand capture, iteration datapath and final conditional subtraction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      n_q      <= '0;
      s_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (n[0]) begin
              a_q   <= a;
              b_q   <= sq ? a : b;
              n_q   <= n;
              s_q   <= '0;
              cnt_q <= '0;
            end else begin
              result_q <= '0;
              err_q    <= 1'b1;
            end
          end
        end
        ITER: begin
          s_q   <= s_next;
          a_q   <= a_q >> 1;
          cnt_q <= cnt_q + CW'(1);
        end
        CORR: begin
          result_q <= s_ge_n ? (s_q[M-1:0] - n_q) : s_q[M-1:0];
          err_q    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign result = result_q;
  assign err    = err_q;

endmodule

// File: tb/tb_mr2mmm_unit.sv
module tb_mr2mmm_unit;

  localparam int M = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sq = 1'b0;
  logic [M-1:0] a = '0, b = '0, n = '0;
  logic [M-1:0] result;
  logic         done, busy, err;

  int n_cmp = 0;
  int n_bad = 0;

  mr2mmm_unit #(.M(M)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sq     (sq),
    .a      (a),
    .b      (b),
    .n      (n),
    .result (result),
    .done   (done),
    .busy   (busy),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: the unique R in [0,N) with R*2^M == A*B (mod N).
  function automatic int mont_ref(input int ra, input int rb, input int rn);
    int p;
    p = (ra * rb) % rn;
    for (int r = 0; r < rn; r++)
      if (((r * (1 << M)) % rn) == p) return r;
    return -1;
  endfunction

  // Issue one operation from IDLE and check latency, busy, result, err, pulse width.
  task automatic do_op(input string tag, input int ta, input int tb, input int tn, input bit tsq);
    int lat, exp_res, exp_lat, exp_err, eb;
    eb = tsq ? ta : tb;
    if (tn % 2 == 1) begin
      exp_res = mont_ref(ta, eb, tn);
      exp_lat = M + 1;
      exp_err = 0;
    end else begin
      exp_res = 0;
      exp_lat = 0;
      exp_err = 1;
    end
    @(negedge clk);
    a = ta[M-1:0]; b = tb[M-1:0]; n = tn[M-1:0]; sq = tsq; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = M'($urandom); b = M'($urandom); n = M'($urandom); sq = 1'($urandom);
    @(negedge clk);
    chk({tag, ".busy"}, int'(busy), 1);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".lat"}, lat, exp_lat);
    chk({tag, ".res"}, int'(result), exp_res);
    chk({tag, ".err"}, int'(err), exp_err);
    @(negedge clk);
    chk({tag, ".pulse"}, int'(done), 0);
    chk({tag, ".idle"}, int'(busy), 0);
  endtask

  initial begin
    int ra, rb, rn, dcnt, since, last_done, cyc;

    #12;
    chk("rst.result", int'(result), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.err", int'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
    do_op("basic", 5, 7, 239, 1'b0);
    do_op("square", 3, 200, 239, 1'b1);
    do_op("nminus1", 238, 1, 239, 1'b0);
    do_op("zero", 0, 100, 239, 1'b0);
    do_op("evenN", 5, 7, 240, 1'b0);
    do_op("clrerr", 5, 7, 239, 1'b0);
    do_op("maxN", 254, 254, 255, 1'b0);

    // Randomized operations against the arithmetic reference.
    for (int i = 0; i < 24; i++) begin
      rn = $urandom_range(255, 3);
      if ($urandom_range(7, 0) != 0) rn = rn | 1;
      ra = $urandom_range(rn - 1, 0);
      rb = $urandom_range(rn - 1, 0);
      do_op("rand", ra, rb, rn, 1'($urandom));
    end

    // Reset asserted in the 4th iteration cycle.
    do_op("prerst", 5, 7, 239, 1'b0);
    @(negedge clk);
    a = 8'd5; b = 8'd7; n = 8'd239; sq = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.result", int'(result), 0);
    chk("midrst.done", int'(done), 0);
    chk("midrst.busy", int'(busy), 0);
    chk("midrst.err", int'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("midrst.nodone", dcnt, 0);
    do_op("postrst", 5, 7, 239, 1'b0);

    // Start held high: back-to-back operations.
    @(negedge clk);
    a = 8'd5; b = 8'd7; n = 8'd239; sq = 1'b0; start = 1'b1;
    last_done = -1; since = 100; dcnt = 0;
    for (cyc = 0; cyc < 34; cyc++) begin
      @(negedge clk);
      since++;
      if (since == 1) chk("b2b.gap", int'(busy), 0);
      if (since == 2) chk("b2b.rebusy", int'(busy), 1);
      if (done) begin
        dcnt++;
        chk("b2b.res", int'(result), 227);
        chk("b2b.err", int'(err), 0);
        if (last_done >= 0) chk("b2b.period", cyc - last_done, 11);
        last_done = cyc;
        since = 0;
      end
    end
    chk("b2b.count", dcnt, 3);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("b2b.drain", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mr2mmm_unit.md
MR2MMM_UNIT -- requirements
Module: mr2mmm_unit

Interface
REQ-001 Parameter: M, default 8, operand/modulus width in bits (M >= 4).
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous and active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 sq  input  1  squaring mode; 1 -> B operand taken as A, b input ignored.
REQ-006 a  input  M  multiplicand A; requires A < N.
REQ-007 b  input  M  multiplier B; requires B < N.
REQ-008 n  input  M  modulus N; must be odd.
REQ-009 result  output  M  A*B*2^-M mod N; held until the next accepted start.
REQ-010 done  output  1  single-cycle pulse; result/err valid.
REQ-011 busy  output  1  high from the accepting edge until done drops.
REQ-012 err  output  1  high with done when N was even; held with result.

Function
REQ-013 The FSM SHALL have states IDLE, ITER, CORR and DONE.
REQ-014 In IDLE, start=1 with n[0]=1 SHALL do the following on the same edge, then go to ITER:
- latch A, B (A if sq=1) and N;
- clear accumulator S (M+2 bits) and iteration counter.
REQ-015 In IDLE, start=1 with n[0]=0 SHALL set result=0 and err=1, then go directly to DONE.
REQ-016 Each ITER cycle SHALL perform exactly one radix-2 step:
- q = S[0] XOR (a_i AND B[0]);
- S <= (S + a_i*B + q*N) >> 1, with i = counter, LSB first.
REQ-017 ITER SHALL run exactly M cycles, then go to CORR.
REQ-018 CORR SHALL register result = S-N if S >= N, else S[M-1:0], clear err, then go to DONE.
REQ-019 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-020 Latency: for odd N, done SHALL be high in the cycle following edge k+M+1, where k is the accepting edge.
REQ-021 Latency: for even N, done SHALL be high in the cycle following edge k.
REQ-022 start SHALL be ignored outside IDLE; inputs may change freely after the accepting edge.
REQ-023 start held high SHALL begin a new operation on the edge after DONE (back-to-back operation, one idle cycle).
REQ-024 S SHALL never overflow M+2 bits, given A, B < N.
REQ-025 Operands violating A, B < N SHALL give an unspecified result but the same timing, and no lock-up.

Reset
REQ-026 rst_n=0 SHALL immediately force the following, regardless of the current state, including mid-ITER:
- state IDLE;
- result=0, done=0, busy=0, err=0;
- S=0, counter=0, operand registers=0.
REQ-027 After rst_n deasserts, the first start SHALL be accepted on the first rising edge at which it is sampled high.

Structure
REQ-028 Package mr2mmm_pkg SHALL hold the FSM state typedef/encodings and the default width constant.
REQ-029 One combinational sub-module, mr2mmm_step, SHALL implement a single REQ-016 iteration:
- inputs S, a_i, B, N;
- output next S.
REQ-030 The counter SHALL be $clog2(M+1) bits wide.

Verification (M=8, N=239 unless stated)
REQ-031 A=5, B=7, sq=0 -> result=227, err=0, done high 9 cycles after the accepting edge.
REQ-032 A=3, sq=1, b=200 -> result=113 (b ignored).
REQ-033 A=238, B=1 -> result=14; A=0, B=100 -> result=0.
REQ-034 N=240, start -> done the next cycle, err=1, result=0; the following valid operation clears err.
REQ-035 rst_n pulsed low during the 4th ITER cycle -> all outputs 0 immediately, no done pulse; a new start gives the correct result.
REQ-036 start held high for 30 cycles with A=5, B=7 -> repeated done pulses every 11 cycles, all with result=227; busy low exactly one cycle between operations.
